// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD datapath: op encodings, operand-register FSM states.
package gcd_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_CNT_WIDTH  = 8;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'b00,
        OP_SUB_A = 2'b01,
        OP_SUB_B = 2'b10,
        OP_SWAP  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    function automatic logic is_sub(input op_t op);
        return (op == OP_SUB_A) || (op == OP_SUB_B);
    endfunction

endpackage

// File: rtl/gcd_operand_regs_if.sv
// Operand bus between the input side / GCD controller (master) and the operand registers (slave).
interface gcd_operand_regs_if
    import gcd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
);

    logic [DATA_WIDTH-1:0] data_in;
    logic                  in_valid;
    logic                  in_ready;
    op_t                   op;
    logic                  clr;
    logic [DATA_WIDTH-1:0] A_out;
    logic [DATA_WIDTH-1:0] B_out;
    logic                  ops_valid;
    logic                  a_eq_b;
    logic                  a_lt_b;
    logic                  b_zero;
    logic [CNT_WIDTH-1:0]  step_cnt;
    logic                  cnt_sat;

    modport master (
        output data_in, in_valid, op, clr,
        input  in_ready, A_out, B_out, ops_valid, a_eq_b, a_lt_b, b_zero, step_cnt, cnt_sat
    );

    modport slave (
        input  data_in, in_valid, op, clr,
        output in_ready, A_out, B_out, ops_valid, a_eq_b, a_lt_b, b_zero, step_cnt, cnt_sat
    );

endinterface

// File: rtl/gcd_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module gcd_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_sat
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;
    logic             w_sat;

    assign w_sat = &r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_sat) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = w_sat;

endmodule

// File: rtl/gcd_operand_regs.sv
// GCD operand register pair: captures A then B from a shared bus, then executes
// SUB_A / SUB_B / SWAP commands and exports comparison flags and a step count.
module gcd_operand_regs
    import gcd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst,
    gcd_operand_regs_if.slave  bus
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] w_a_nxt;
    logic [DATA_WIDTH-1:0] w_b_nxt;
    logic                  w_in_ready;
    logic                  w_ops_valid;
    logic                  w_cnt_clr;
    logic                  w_cnt_inc;
    logic [CNT_WIDTH-1:0]  w_cnt;
    logic                  w_cnt_sat;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_LOAD_A;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_in_ready  = 1'b0;
        w_ops_valid = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;

        case (r_state)
            ST_LOAD_A: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_a_nxt     = bus.data_in;
                    w_state_nxt = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_b_nxt     = bus.data_in;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_ops_valid = 1'b1;
                w_cnt_inc   = is_sub(bus.op);
                case (bus.op)
                    OP_SUB_A: w_a_nxt = r_a - r_b;
                    OP_SUB_B: w_b_nxt = r_b - r_a;
                    OP_SWAP: begin
                        w_a_nxt = r_b;
                        w_b_nxt = r_a;
                    end
                    OP_HOLD: ;
                    default: ;
                endcase
            end
            default: w_state_nxt = ST_LOAD_A;
        endcase

        // clr overrides any capture or command decided above; the handshake
        // outputs stay state-only so in_ready never depends on in_valid/clr.
        if (bus.clr) begin
            w_state_nxt = ST_LOAD_A;
            w_a_nxt     = r_a;
            w_b_nxt     = r_b;
            w_cnt_clr   = 1'b1;
            w_cnt_inc   = 1'b0;
        end
    end

    gcd_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_step_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_cnt_clr),
        .i_inc (w_cnt_inc),
        .o_cnt (w_cnt),
        .o_sat (w_cnt_sat)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.ops_valid = w_ops_valid;
    assign bus.A_out     = r_a;
    assign bus.B_out     = r_b;
    assign bus.a_eq_b    = (r_a == r_b);
    assign bus.a_lt_b    = (r_a < r_b);
    assign bus.b_zero    = (r_b == '0);
    assign bus.step_cnt  = w_cnt;
    assign bus.cnt_sat   = w_cnt_sat;

endmodule

// File: tb/tb_gcd_operand_regs.sv
// Directed bench for gcd_operand_regs (DATA_WIDTH=8, CNT_WIDTH=3) with hand-computed expectations.
module tb_gcd_operand_regs;
    import gcd_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 i_clk = ~i_clk;

    gcd_operand_regs_if #(.DATA_WIDTH(8), .CNT_WIDTH(3)) bus ();

    gcd_operand_regs #(
        .DATA_WIDTH (8),
        .CNT_WIDTH  (3)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        bus.data_in  = '0;
        bus.in_valid = 1'b0;
        bus.op       = OP_HOLD;
        bus.clr      = 1'b0;

        // reset
        tick();
        tick();
        i_rst = 1'b0;
        chk("rst_a",         32'(bus.A_out),     0);
        chk("rst_b",         32'(bus.B_out),     0);
        chk("rst_in_ready",  32'(bus.in_ready),  1);
        chk("rst_ops_valid", 32'(bus.ops_valid), 0);
        chk("rst_a_eq_b",    32'(bus.a_eq_b),    1);
        chk("rst_a_lt_b",    32'(bus.a_lt_b),    0);
        chk("rst_b_zero",    32'(bus.b_zero),    1);
        chk("rst_step",      32'(bus.step_cnt),  0);
        chk("rst_sat",       32'(bus.cnt_sat),   0);
        tick();
        chk("idle_in_ready", 32'(bus.in_ready),  1);
        chk("idle_a",        32'(bus.A_out),     0);

        // capture 48, gap of two cycles, then 18
        bus.data_in = 8'd48; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("cap_a",          32'(bus.A_out),     48);
        chk("cap_a_in_ready", 32'(bus.in_ready),  1);
        chk("cap_a_ops",      32'(bus.ops_valid), 0);
        tick();
        tick();
        chk("gap_b_held",     32'(bus.B_out),     0);
        chk("gap_ops",        32'(bus.ops_valid), 0);
        bus.data_in = 8'd18; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("cap_b",          32'(bus.B_out),     18);
        chk("cap_b_a",        32'(bus.A_out),     48);
        chk("cap_ops_valid",  32'(bus.ops_valid), 1);
        chk("cap_in_ready",   32'(bus.in_ready),  0);
        chk("cap_step",       32'(bus.step_cnt),  0);

        // full GCD run, bounded
        for (int i = 0; i < 20; i++) begin
            if (bus.a_eq_b) break;
            bus.op = (!bus.a_lt_b) ? OP_SUB_A : OP_SWAP;
            tick();
        end
        bus.op = OP_HOLD;
        chk("gcd_done",  32'(bus.a_eq_b),    1);
        chk("gcd_a",     32'(bus.A_out),     6);
        chk("gcd_b",     32'(bus.B_out),     6);
        chk("gcd_steps", 32'(bus.step_cnt),  4);
        chk("gcd_ops",   32'(bus.ops_valid), 1);

        // clr back to capture; registers hold
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk("clr_in_ready", 32'(bus.in_ready),  1);
        chk("clr_ops",      32'(bus.ops_valid), 0);
        chk("clr_step",     32'(bus.step_cnt),  0);
        chk("clr_a_held",   32'(bus.A_out),     6);

        // wrap: 5 - 9 = 252; in_valid ignored in RUN
        bus.data_in = 8'd5; bus.in_valid = 1'b1;
        tick();
        bus.data_in = 8'd9;
        tick();
        bus.data_in = 8'd77; bus.op = OP_SUB_A;
        tick();
        bus.op = OP_HOLD;
        chk("wrap_a",     32'(bus.A_out),    252);
        chk("wrap_b",     32'(bus.B_out),    9);
        chk("wrap_step",  32'(bus.step_cnt), 1);
        chk("wrap_lt",    32'(bus.a_lt_b),   0);
        tick();
        chk("ign_a",      32'(bus.A_out),    252);
        chk("ign_b",      32'(bus.B_out),    9);
        bus.in_valid = 1'b0;
        bus.op = OP_SUB_B;
        tick();
        chk("subb_b",     32'(bus.B_out),    13);
        chk("subb_step",  32'(bus.step_cnt), 2);
        bus.op = OP_SWAP;
        tick();
        bus.op = OP_HOLD;
        chk("swap_a",     32'(bus.A_out),    13);
        chk("swap_b",     32'(bus.B_out),    252);
        chk("swap_step",  32'(bus.step_cnt), 2);
        chk("swap_lt",    32'(bus.a_lt_b),   1);

        // saturation: 200 / 1, ten SUB_A
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        bus.data_in = 8'd200; bus.in_valid = 1'b1;
        tick();
        bus.data_in = 8'd1;
        tick();
        bus.in_valid = 1'b0;
        bus.op = OP_SUB_A;
        for (int i = 0; i < 10; i++) tick();
        bus.op = OP_HOLD;
        chk("sat_step",   32'(bus.step_cnt), 7);
        chk("sat_flag",   32'(bus.cnt_sat),  1);
        chk("sat_a",      32'(bus.A_out),    190);
        chk("sat_b",      32'(bus.B_out),    1);
        chk("sat_bzero",  32'(bus.b_zero),   0);

        // clr priority over op and in_valid
        bus.clr = 1'b1; bus.op = OP_SUB_A; bus.in_valid = 1'b1; bus.data_in = 8'd99;
        tick();
        bus.clr = 1'b0; bus.op = OP_HOLD; bus.data_in = 8'd12;
        chk("clrp_a",        32'(bus.A_out),     190);
        chk("clrp_b",        32'(bus.B_out),     1);
        chk("clrp_in_ready", 32'(bus.in_ready),  1);
        chk("clrp_ops",      32'(bus.ops_valid), 0);
        chk("clrp_step",     32'(bus.step_cnt),  0);
        chk("clrp_sat",      32'(bus.cnt_sat),   0);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_a",         32'(bus.A_out),     12);
        chk("b2b_b",         32'(bus.B_out),     1);
        chk("b2b_in_ready",  32'(bus.in_ready),  1);
        chk("b2b_ops",       32'(bus.ops_valid), 0);

        // reset while in RUN
        bus.data_in = 8'd3; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("run2_ops",      32'(bus.ops_valid), 1);
        i_rst = 1'b1; bus.op = OP_SUB_A;
        tick();
        i_rst = 1'b0; bus.op = OP_HOLD;
        chk("rrun_ops",      32'(bus.ops_valid), 0);
        chk("rrun_a",        32'(bus.A_out),     0);
        chk("rrun_b",        32'(bus.B_out),     0);
        chk("rrun_in_ready", 32'(bus.in_ready),  1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gcd_operand_regs.md
# gcd_operand_regs

Parametrised operand register pair for the GCD datapath. It replaces the single load-enable operand register with one block that captures A and B in sequence from a shared input bus under a valid/ready handshake. It then executes subtract and swap commands from the GCD controller, and exports the comparison flags and a saturating step counter. It sits between the input interface and the GCD control FSM.

## Interface
- DATA_WIDTH, 8, width of A, B and data_in
- CNT_WIDTH, 8, width of step counter
- i_clk  in  1  rising-edge clock; the block has one clock
- i_rst  in  1  reset, synchronous and active-high
- data_in  in  DATA_WIDTH  operand input bus, shared by A and B
- in_valid  in  1  data_in holds a valid operand
- in_ready  out  1  block accepts an operand this cycle
- op  in  2  command: 00 hold, 01 SUB_A, 10 SUB_B, 11 SWAP
- clr  in  1  abort current pair and return to operand capture
- A_out  out  DATA_WIDTH  registered A
- B_out  out  DATA_WIDTH  registered B
- ops_valid  out  1  both operands captured; op is accepted
- a_eq_b  out  1  A_out == B_out (combinational from registers)
- a_lt_b  out  1  A_out < B_out, unsigned
- b_zero  out  1  B_out == 0
- step_cnt  out  CNT_WIDTH  count of SUB_A/SUB_B executed since the last capture
- cnt_sat  out  1  step_cnt == all ones

## Operation
- FSM states: LOAD_A, LOAD_B, RUN. Encoding is internal.
- LOAD_A: in_ready=1. On in_valid, A <= data_in and the FSM goes to LOAD_B.
- LOAD_B: in_ready=1. On in_valid, B <= data_in, step_cnt <= 0, and the FSM goes to RUN.
- RUN: in_ready=0 and ops_valid=1. in_valid is ignored.
  - SUB_A: A <= A - B.
  - SUB_B: B <= B - A.
  - SWAP: A <= B and B <= A in the same edge.
  - 00: A and B are held.
- op is ignored in LOAD_A and LOAD_B.
- Arithmetic is modulo 2^DATA_WIDTH. Underflow wraps and raises no flag. The controller uses a_lt_b to avoid underflow.
- step_cnt increments on each SUB_A or SUB_B executed in RUN. It saturates at 2^CNT_WIDTH-1. SWAP and hold do not count.
- clr, in any state: the FSM goes to LOAD_A, step_cnt <= 0, and A and B hold their values. clr has priority over op and over in_valid. An operand presented with clr in the same cycle is not captured.
- The FSM stays in RUN until clr or i_rst. There is no automatic termination; the controller decides completion from a_eq_b and b_zero.
- Flags are derived combinationally from the current register values only, never from data_in or op.

## Timing
- Reset values: A_out=0, B_out=0, state LOAD_A, in_ready=1, ops_valid=0, step_cnt=0, cnt_sat=0, a_eq_b=1, a_lt_b=0, b_zero=1.
- i_rst is sampled on the rising edge and overrides clr, in_valid and op. Reset in RUN drops ops_valid on the next cycle.
- Capture: transfer occurs on the edge where in_valid && in_ready. The value is visible on A_out or B_out in the following cycle.
- ops_valid rises in the cycle after the B transfer. First op accepted on that same cycle's edge.
- op latency: 1 cycle. Flags update combinationally in the same cycle as the new register values.
- in_ready is a function of state only, with no dependency on in_valid, so there is no combinational loop.
- Back-to-back pairs: after clr, A can be captured on the very next edge.

## Structure
- Shared package gcd_pkg holds:
  - op encodings (OP_HOLD, OP_SUB_A, OP_SUB_B, OP_SWAP)
  - FSM state type and encodings
  - the default DATA_WIDTH and CNT_WIDTH
- One natural sub-module: gcd_sat_counter, the parametrised saturating counter with sync clear. Everything else stays in this module.

## Test plan
- Reset then idle: after i_rst, A_out=0, B_out=0, in_ready=1, ops_valid=0, a_eq_b=1, b_zero=1.
- Capture with gaps: present 48 with in_valid, drop in_valid 2 cycles, then present 18. Required: A_out=48, B_out=18, ops_valid=1 one cycle after the second transfer, in_ready=0.
- Full GCD run on 48/18: issue SUB_A whenever !a_lt_b and !a_eq_b, otherwise SWAP, stop on a_eq_b. Required: final A_out=B_out=6, step_cnt=4, ops_valid still 1.
- Wrap and ignore: with A=5 and B=9, issue SUB_A, giving A=252 for DATA_WIDTH=8. in_valid with data_in=77 during RUN leaves A and B unchanged.
- Saturation: with CNT_WIDTH=3, A=200 and B=1, issue 10 SUB_A. Required: step_cnt=7, cnt_sat=1, A_out=190.
- clr priority: assert clr together with op=SUB_A and in_valid in RUN. Required: A and B unchanged, state LOAD_A, step_cnt=0, no capture. Next-cycle in_valid with 12 gives A_out=12.
